// File: rtl/assoc_cache.sv
// Set-associative, write-through, no-write-allocate cache with true-LRU replacement.
// Optional one-entry posted write buffer: define WRITE_BUFFER_EN.
module assoc_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      c__read_m,
  input  logic                      c__write_m,
  input  logic [15:0]               addr,
  input  logic [15:0]               i__data,
  output logic [15:0]               o__data,
  output logic                      c__ready,
  output logic                      m__read_m,
  output logic                      m__write_m,
  output logic [15:0]               m__addr,
  output logic [15:0]               m__size,
  output logic [15:0]               m__data_out,
  input  logic [16*LINE_WORDS-1:0]  m__data_in,
  input  logic                      m__ready,
  output logic [15:0]               hit_count,
  output logic [15:0]               miss_count
);

  localparam int OFFW = $clog2(LINE_WORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 16 - OFFW - IDXW;
  localparam int OFFB = (OFFW > 0) ? OFFW : 1;
  localparam int IDXB = (IDXW > 0) ? IDXW : 1;
  localparam int AGEB = (WAYS > 1) ? $clog2(WAYS) : 1;

`ifdef WRITE_BUFFER_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  typedef enum logic [1:0] {READY, LOOKUP, MEM_RD, MEM_WR} state_t;

  state_t state_q, state_d;

  logic [15:0] a_q, d_q;
  logic        wr_q;
  logic [15:0] o_data_q, m_addr_q, m_size_q, m_data_out_q, hit_q, miss_q;
  logic        m_read_q, m_write_q;

  logic [WAYS-1:0][SETS-1:0]                       valid_q;
  logic [WAYS-1:0][SETS-1:0][TAGW-1:0]             tag_q;
  logic [WAYS-1:0][SETS-1:0][AGEB-1:0]             age_q;
  logic [WAYS-1:0][SETS-1:0][LINE_WORDS-1:0][15:0] data_q;

  logic [LINE_WORDS-1:0][15:0] line_in;
  logic [OFFB-1:0] off;
  logic [IDXB-1:0] idx;
  logic [TAGW-1:0] tag;
  logic [AGEB-1:0] hit_way, victim, pway;
  logic            hit, vic_found, wb_busy;
  logic            accept, count, rd_hit, wr_hit, issue_rd, issue_wr, fill, end_wr, promote;

  assign line_in = m__data_in;
  assign off     = OFFB'(a_q & 16'(LINE_WORDS-1));
  assign idx     = IDXB'((a_q >> OFFW) & 16'(SETS-1));
  assign tag     = TAGW'(a_q >> (OFFW + IDXW));
  assign wb_busy = WBUF && m_write_q;
  assign end_wr  = m_write_q && m__ready;
  assign promote = rd_hit || fill;
  assign pway    = fill ? victim : hit_way;

  // Tag match across the set, and victim choice: first invalid way, else the oldest.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    victim    = '0;
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = AGEB'(w);
      end
      if (!vic_found && !valid_q[w][idx]) begin
        vic_found = 1'b1;
        victim    = AGEB'(w);
      end
    end
    if (!vic_found)
      for (int w = 0; w < WAYS; w++)
        if (age_q[w][idx] == AGEB'(WAYS-1)) victim = AGEB'(w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= READY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    count    = 1'b0;
    rd_hit   = 1'b0;
    wr_hit   = 1'b0;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    fill     = 1'b0;
    case (state_q)
      READY: if (c__read_m || c__write_m) begin
        accept  = 1'b1;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        // With the buffer busy, writes and read misses hold here until the drain ends.
        if (wr_q) begin
          if (!wb_busy) begin
            count    = 1'b1;
            wr_hit   = hit;
            issue_wr = 1'b1;
            state_d  = WBUF ? READY : MEM_WR;
          end
        end else if (hit) begin
          count   = 1'b1;
          rd_hit  = 1'b1;
          state_d = READY;
        end else if (!wb_busy) begin
          count    = 1'b1;
          issue_rd = 1'b1;
          state_d  = MEM_RD;
        end
      end
      MEM_RD: if (m__ready) begin
        fill    = 1'b1;
        state_d = READY;
      end
      MEM_WR: if (m__ready) state_d = READY;
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q          <= '0;
      d_q          <= '0;
      wr_q         <= 1'b0;
      o_data_q     <= '0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= '0;
      m_size_q     <= '0;
      m_data_out_q <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      valid_q      <= '0;
      tag_q        <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) age_q[w][s] <= AGEB'(w);
    end else begin
      if (accept) begin
        a_q  <= addr;
        d_q  <= i__data;
        wr_q <= c__write_m && !c__read_m;
      end
      if (count) begin
        if (hit) hit_q  <= hit_q + 16'd1;
        else     miss_q <= miss_q + 16'd1;
      end
      if (rd_hit) o_data_q <= data_q[hit_way][idx][off];
      if (issue_rd) begin
        m_read_q <= 1'b1;
        m_addr_q <= a_q & ~16'(LINE_WORDS-1);
        m_size_q <= 16'(16*LINE_WORDS);
      end
      if (fill) begin
        valid_q[victim][idx] <= 1'b1;
        tag_q[victim][idx]   <= tag;
        o_data_q             <= line_in[off];
        m_read_q             <= 1'b0;
      end
      if (issue_wr) begin
        m_write_q    <= 1'b1;
        m_addr_q     <= a_q;
        m_size_q     <= 16'd16;
        m_data_out_q <= d_q;
      end
      if (end_wr) m_write_q <= 1'b0;
      // Promote to MRU: only ways younger than the promoted one age, keeping a permutation.
      if (promote)
        for (int w = 0; w < WAYS; w++) begin
          if (AGEB'(w) == pway)                      age_q[w][idx] <= '0;
          else if (age_q[w][idx] < age_q[pway][idx]) age_q[w][idx] <= age_q[w][idx] + 1'b1;
        end
    end
  end

  always_ff @(posedge clk) begin
    if (fill)   data_q[victim][idx]       <= line_in;
    if (wr_hit) data_q[hit_way][idx][off] <= d_q;
  end

  assign c__ready    = (state_q == READY);
  assign o__data     = o_data_q;
  assign m__read_m   = m_read_q;
  assign m__write_m  = m_write_q;
  assign m__addr     = m_addr_q;
  assign m__size     = m_size_q;
  assign m__data_out = m_data_out_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed vector table, reset/abort sequences, and random traffic
// checked against a recency-list cache model plus a flat memory model.
module tb_assoc_cache;
  localparam int WAYS = 2, SETS = 2, LW = 4;

  logic clk = 1'b0;
  logic reset, c__read_m, c__write_m, c__ready, m__read_m, m__write_m, m__ready;
  logic [15:0] addr, i__data, o__data, m__addr, m__size, m__data_out, hit_count, miss_count;
  logic [16*LW-1:0] m__data_in;

  always #5 clk = ~clk;

  assoc_cache #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .c__read_m(c__read_m), .c__write_m(c__write_m),
    .addr(addr), .i__data(i__data), .o__data(o__data), .c__ready(c__ready),
    .m__read_m(m__read_m), .m__write_m(m__write_m), .m__addr(m__addr), .m__size(m__size),
    .m__data_out(m__data_out), .m__data_in(m__data_in), .m__ready(m__ready),
    .hit_count(hit_count), .miss_count(miss_count));

  int tests = 0, fails = 0, lat = 3;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] lines [$];   // resident lines, most recently used first
  int exp_hits = 0, exp_misses = 0;
  bit rd_seen, wr_seen;
  logic [15:0] last_rd_addr, last_rd_size, last_wr_addr, last_wr_size, last_wr_data;

  always_comb begin
    m__data_in = '0;
    for (int k = 0; k < LW; k++) m__data_in[k*16 +: 16] = mem[16'(m__addr + 16'(k))];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory: answers each request lat cycles later; abandons it if reset appears.
  initial begin
    m__ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && (m__read_m || m__write_m)) begin
        bit isrd, abort;
        logic [15:0] ca, cs, cd;
        isrd = m__read_m; ca = m__addr; cs = m__size; cd = m__data_out; abort = 1'b0;
        if (isrd) begin rd_seen = 1'b1; last_rd_addr = ca; last_rd_size = cs; end
        else begin wr_seen = 1'b1; last_wr_addr = ca; last_wr_size = cs; last_wr_data = cd; end
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (reset) begin abort = 1'b1; break; end
          check("mem_hold", {m__read_m, m__write_m, m__addr, m__size, m__data_out},
                {isrd, !isrd, ca, cs, cd});
        end
        if (!abort) begin
          if (!isrd) mem[ca] = cd;
          m__ready = 1'b1;
          @(negedge clk);
          m__ready = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m__read_m && m__write_m) begin
      fails++;
      $display("FAIL both_req: read and write requested together at %0t", $time);
    end
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic model(input bit rd, input logic [15:0] a, input logic [15:0] wd, output bit hit);
    logic [15:0] line;
    int set, pos, cnt, last;
    line = a & ~16'(LW-1);
    set  = int'(a / LW) % SETS;
    pos  = -1;
    foreach (lines[i]) if (lines[i] == line) pos = i;
    hit = (pos >= 0);
    if (hit) exp_hits++; else exp_misses++;
    if (rd) begin
      if (hit) lines.delete(pos);
      else begin
        cnt = 0; last = -1;
        foreach (lines[i]) if ((int'(lines[i] / LW) % SETS) == set) begin cnt++; last = i; end
        if (cnt >= WAYS) lines.delete(last);
      end
      lines.push_front(line);
    end else ref_mem[a] = wd;
  endtask

  // cyc counts falling edges from acceptance until c__ready is seen high again.
  task automatic do_op(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                       input bit drain, output bit got_mrd, output int cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!c__ready && n < 200) begin @(negedge clk); n++; end
    if (!c__ready) check("ready_wait_timeout", 0, 1);
    rd_seen = 1'b0; wr_seen = 1'b0;
    c__read_m = rd; c__write_m = wr; addr = a; i__data = wd;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin c__read_m = 1'b0; c__write_m = 1'b0; end
    end while (!c__ready && cyc < 200);
    if (!c__ready) check("done_wait_timeout", 0, 1);
    if (drain) begin
      n = 0;
      while (m__write_m && n < 200) begin @(negedge clk); n++; end
      if (m__write_m) check("drain_timeout", 0, 1);
    end
    got_mrd = rd_seen;
  endtask

  task automatic run_check(input string nm, input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] wd, input bit drain);
    bit h, mrd;
    int cyc;
    model(rd, a, wd, h);
    do_op(rd, wr, a, wd, drain, mrd, cyc);
    check({nm, "_mrd"}, mrd, rd && !h);
    if (rd) check({nm, "_data"}, o__data, ref_mem[a]);
    if (rd && h) check({nm, "_lat"}, cyc, 2);
    check({nm, "_hits"}, hit_count, exp_hits);
    check({nm, "_misses"}, miss_count, exp_misses);
  endtask

  typedef struct {
    bit          rd;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp_d;
    bit          exp_miss;
    int          exp_h;
    int          exp_m;
  } vec_t;

  initial begin
    vec_t vt [11];
    bit h, mrd, rd, wr;
    int cyc, n;
    logic [15:0] a, wd;

    // Set 0 lines: A=0x10, B=0x20, C=0x30; 0x44 lives in set 1.
    vt[0]  = '{1'b1, 16'h0010, 16'h0000, 16'h0001, 1'b1, 0, 1};
    vt[1]  = '{1'b1, 16'h0012, 16'h0000, 16'h0003, 1'b0, 1, 1};
    vt[2]  = '{1'b1, 16'h0020, 16'h0000, 16'h5A20, 1'b1, 1, 2};
    vt[3]  = '{1'b1, 16'h0011, 16'h0000, 16'h0002, 1'b0, 2, 2};
    vt[4]  = '{1'b1, 16'h0031, 16'h0000, 16'h5A31, 1'b1, 2, 3};
    vt[5]  = '{1'b1, 16'h0013, 16'h0000, 16'h0004, 1'b0, 3, 3};
    vt[6]  = '{1'b1, 16'h0022, 16'h0000, 16'h5A22, 1'b1, 3, 4};
    vt[7]  = '{1'b0, 16'h0011, 16'hBEEF, 16'h0000, 1'b0, 4, 4};
    vt[8]  = '{1'b1, 16'h0011, 16'h0000, 16'hBEEF, 1'b0, 5, 4};
    vt[9]  = '{1'b0, 16'h0044, 16'h1234, 16'h0000, 1'b1, 5, 5};
    vt[10] = '{1'b1, 16'h0044, 16'h0000, 16'h1234, 1'b1, 5, 6};

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i) ^ 16'h5A00;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16 + i] = 16'(i + 1);
      ref_mem[16 + i] = 16'(i + 1);
    end

    reset = 1'b1; c__read_m = 1'b0; c__write_m = 1'b0; addr = '0; i__data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", c__ready, 1);
    check("rst_odata", o__data, 0);
    check("rst_mreq", {m__read_m, m__write_m}, 0);
    check("rst_maddr_size_data", {m__addr, m__size, m__data_out}, 0);
    check("rst_counts", {hit_count, miss_count}, 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      model(vt[i].rd, vt[i].a, vt[i].wd, h);
      do_op(vt[i].rd, !vt[i].rd, vt[i].a, vt[i].wd, 1'b1, mrd, cyc);
      if (vt[i].rd) begin
        check($sformatf("v%0d_data", i), o__data, vt[i].exp_d);
        check($sformatf("v%0d_mrd", i), mrd, vt[i].exp_miss);
        if (vt[i].exp_miss) begin
          check($sformatf("v%0d_rd_addr", i), last_rd_addr, vt[i].a & 16'hFFFC);
          check($sformatf("v%0d_rd_size", i), last_rd_size, 16'd64);
        end else check($sformatf("v%0d_lat", i), cyc, 2);
      end else begin
        check($sformatf("v%0d_wr_seen", i), wr_seen, 1);
        check($sformatf("v%0d_wr_fields", i), {last_wr_addr, last_wr_size, last_wr_data},
              {vt[i].a, 16'd16, vt[i].wd});
      end
      check($sformatf("v%0d_hits", i), hit_count, vt[i].exp_h);
      check($sformatf("v%0d_misses", i), miss_count, vt[i].exp_m);
    end

`ifdef WRITE_BUFFER_EN
    lat = 6;
    model(1'b0, 16'h0012, 16'h1111, h);
    do_op(1'b0, 1'b1, 16'h0012, 16'h1111, 1'b0, mrd, cyc);
    check("wb_wr_lat", cyc, 2);
    check("wb_draining", m__write_m, 1);
    model(1'b1, 16'h0012, 16'h0000, h);
    do_op(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, mrd, cyc);
    check("wb_rdhit_lat", cyc, 2);
    check("wb_rdhit_data", o__data, 16'h1111);
    check("wb_rdhit_during_drain", {m__write_m, mrd}, 2'b10);
    run_check("wb_wmiss", 1'b0, 1'b1, 16'h0050, 16'h7777, 1'b0);
    run_check("wb_rmiss_after_drain", 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1);
    lat = 3;
`endif

    // Reset while a line fill is outstanding.
    lat = 30;
    @(negedge clk);
    n = 0;
    while (!c__ready && n < 200) begin @(negedge clk); n++; end
    c__read_m = 1'b1; addr = 16'h0084;
    @(posedge clk);
    @(negedge clk);
    c__read_m = 1'b0;
    n = 0;
    while (!m__read_m && n < 10) begin @(negedge clk); n++; end
    check("rst_mid_rd_issued", {m__read_m, m__addr}, {1'b1, 16'h0084});
    #2 reset = 1'b1;
    #1;
    check("rst_mid_rd_drop", m__read_m, 0);
    check("rst_mid_ready", c__ready, 1);
    check("rst_mid_counts", {hit_count, miss_count}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lines.delete();
    exp_hits = 0; exp_misses = 0;
    lat = 3;
    run_check("rst_again", 1'b1, 1'b0, 16'h0084, 16'h0000, 1'b1);
    run_check("rst_a_gone", 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1);

    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      a   = 16'($urandom_range(0, 4) * 8 + $urandom_range(0, 7));
      wd  = 16'($urandom);
      rd  = ($urandom_range(0, 9) < 7);
      wr  = !rd || ($urandom_range(0, 19) == 0);
`ifdef WRITE_BUFFER_EN
      run_check($sformatf("r%0d", i), rd, wr, a, wd, 1'($urandom_range(0, 1)));
`else
      run_check($sformatf("r%0d", i), rd, wr, a, wd, 1'b1);
`endif
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter WAYS, default 2: associativity, power of two, 1..8.
REQ-002 Parameter SETS, default 2: sets per way, power of two, 1..64.
REQ-003 Parameter LINE_WORDS, default 4: 16-bit words per line, power of two, 1..8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 c__read_m / c__write_m  input  1 each  CPU read / write request.
REQ-007 addr  input  16  word address: OFF = low log2(LINE_WORDS) bits, IDX = next log2(SETS) bits, TAG = remaining bits.
REQ-008 i__data  input  16  CPU write data.
REQ-009 o__data  output  16  read data; valid while c__ready=1 after a read.
REQ-010 c__ready  output  1  cache idle and able to accept a request.
REQ-011 m__read_m / m__write_m  output  1 each  memory line-read / word-write request.
REQ-012 m__addr  output  16  memory address: line-aligned for reads, exact word address for writes.
REQ-013 m__size  output  16  transfer size in bits: 16*LINE_WORDS for reads, 16 for writes.
REQ-014 m__data_out  output  16  write word; m__data_in  input  16*LINE_WORDS  read line, word 0 in LSBs.
REQ-015 m__ready  input  1  memory completion; one-cycle pulse ending the current transaction.
REQ-016 hit_count / miss_count  output  16 each  accepted-request hit/miss counters, wrapping at 16'hFFFF.

Function
REQ-017 FSM states: READY, LOOKUP, MEM_RD, MEM_WR; c__ready=1 only in READY.
REQ-018 A request is accepted on a rising edge with c__ready=1 and c__read_m|c__write_m; addr and i__data are latched; state -> LOOKUP.
REQ-019 Simultaneous c__read_m and c__write_m are treated as a read.
REQ-020 LOOKUP compares the latched TAG against all WAYS of set IDX; hit = any valid way matches; exactly one hit counter or miss counter increments.
REQ-021 Read hit: o__data = selected word; way promoted to MRU; -> READY; c__ready high 2 cycles after acceptance.
REQ-022 Read miss: m__read_m=1, m__addr = {TAG,IDX,0}; -> MEM_RD; on m__ready, line written to the first invalid way, else the LRU way; valid set, tag stored, way made MRU, o__data = word OFF of m__data_in, m__read_m=0, -> READY.
REQ-023 Replacement is true LRU: per-way age of log2(WAYS) bits; promoted way gets age 0; ways younger than it increment; ages within a set always form a permutation.
REQ-024 Write is write-through, no-write-allocate: write hit updates the cached word in place with no LRU change; write miss leaves cache contents unchanged.
REQ-025 Every write issues m__write_m=1, m__addr = latched addr, m__size=16, m__data_out = i__data; -> MEM_WR; on m__ready, m__write_m=0, -> READY.
REQ-026 m__read_m and m__write_m are never high together; memory outputs are held stable until m__ready.
REQ-027 m__ready outside MEM_RD/MEM_WR is ignored.

Reset
REQ-028 reset asserted: all valid bits 0, way w age = w, state READY, c__ready=1, o__data=0, memory request/addr/size/data outputs 0, counters 0.
REQ-029 Reset mid-transaction aborts it: requests drop asynchronously, no cache line or counter is updated.

Configuration
REQ-030 WRITE_BUFFER_EN defined: writes post into a one-entry buffer; LOOKUP returns to READY the next cycle; buffer drains to memory per REQ-025 while the cache keeps serving requests.
REQ-031 With WRITE_BUFFER_EN: read hits are served during drain; a read miss or a second write waits in LOOKUP (c__ready=0) until the drain completes, then proceeds; a read miss always reads memory after the drain.
REQ-032 WRITE_BUFFER_EN undefined: no buffer; writes stall in MEM_WR per REQ-025.

Verification
REQ-033 After reset, read 16'h0010 with m__data_in=64'h0004_0003_0002_0001, m__ready after 3 cycles -> o__data=16'h0001, miss_count=1, m__addr=16'h0010.
REQ-034 Read 16'h0012 again -> o__data=16'h0003 two cycles after acceptance, no m__read_m, hit_count=1.
REQ-035 WAYS=2: fill tags A and B in set 0, read A, then miss tag C -> B evicted; read A hits, read B misses.
REQ-036 Write 16'hBEEF to cached 16'h0011 -> m__write_m, m__size=16, m__addr=16'h0011; subsequent read returns 16'hBEEF without m__read_m.
REQ-037 WRITE_BUFFER_EN: write then immediate read hit -> c__ready high 2 cycles after the write, read served during drain; write then read miss -> m__read_m rises only after m__write_m falls.
REQ-038 Assert reset during MEM_RD -> m__read_m=0 immediately; after release, same read misses again.
